// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Constants shared by the boot loader, the instruction memory and the bench:
//   word geometry, memory depth, word-index width and the loader state codes.
package imem_loader_pkg;

  localparam int XLEN           = 32;
  localparam int DEPTH_WORDS    = 256;
  localparam int BYTES_PER_WORD = XLEN / 8;
  // One extra bit so the index can hold DEPTH_WORDS itself.
  localparam int IDX_W          = $clog2(DEPTH_WORDS) + 1;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer
//   Assembles bytes little-endian into XLEN-bit words.
//   Ports:
//     clock, reset      system clock, synchronous active-high reset
//     byte_valid_i      byte_i is consumed on this edge
//     byte_i [7:0]      incoming byte
//     word_o [XLEN-1:0] word as it would be after consuming byte_i; valid as a
//                       complete word only when word_done_o is high
//     word_done_o       byte_i is the last byte of the current word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_i,
  output logic [XLEN-1:0] word_o,
  output logic            word_done_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  shift_q;

  // New bytes enter at the top and shift down, so after a full word the
  // first byte sits in bits [7:0].
  assign word_o      = {byte_i, shift_q[XLEN-1:8]};
  assign word_done_o = byte_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      shift_q <= word_o;
      cnt_q   <= cnt_q + 1'b1;  // wraps to 0 after the last byte of a word
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader: receives a length header, payload and XOR checksum over
//   a byte stream and writes the payload into instruction memory from byte
//   address 0. Keeps the core in reset until the load completes cleanly.
//   Ports:
//     clock, reset        system clock, synchronous active-high reset
//     rx_data, rx_valid   incoming byte stream
//     rx_ready            loader accepts a byte this cycle
//     mem_we/addr/wdata   registered one-cycle write to instruction memory
//     cpu_reset           core reset, low only after a successful load
//     done, error         sticky completion / abort flags
//     dbg_state           current FSM state (state_e encoding)
//   Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
//   rx_ready depends only on the state, never on rx_valid.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            cpu_reset,
  output logic            done,
  output logic            error,
  output logic [2:0]      dbg_state
);

  state_e           state_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] widx_q;
  logic [7:0]       chk_q;
  logic             mem_we_q;
  logic [XLEN-1:0]  mem_addr_q;
  logic [XLEN-1:0]  mem_wdata_q;
  logic             cpu_reset_q;
  logic             done_q;
  logic             error_q;

  logic             accept;
  logic             pk_valid;
  logic [XLEN-1:0]  pk_word;
  logic             pk_done;

  assign rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign accept   = rx_valid && rx_ready;
  // The checksum byte is a lone byte, so it bypasses the packer.
  assign pk_valid = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));

  imem_word_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_data),
    .word_o       (pk_word),
    .word_done_o  (pk_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_LEN;
      len_q       <= '0;
      widx_q      <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_LEN: begin
          if (pk_done) begin
            if (pk_word > XLEN'(DEPTH_WORDS)) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else if (pk_word == '0) begin
              state_q <= ST_CHECK;
            end else begin
              len_q   <= pk_word[IDX_W-1:0];
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) chk_q <= chk_q ^ rx_data;
          if (pk_done) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= XLEN'({widx_q, 2'b00});
            mem_wdata_q <= pk_word;
            widx_q      <= widx_q + 1'b1;
            if ((widx_q + 1'b1) == len_q) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (rx_data == chk_q) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        ST_DONE:  ;
        ST_ERROR: ;
        default: begin
          state_q <= ST_ERROR;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader: drives framed byte streams, predicts
//   every memory write into a queue and compares each mem_we pulse against it.
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            cpu_reset;
  logic            done;
  logic            error;
  logic [2:0]      dbg_state;

  always #5 clock = ~clock;

  imem_loader dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];        // {addr, data}
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt   = 0;
  logic        prev_we  = 1'b0;
  logic [31:0] words[8];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        logic [63:0] e;
        wr_cnt++;
        if (prev_we) check("we_width", 64'(prev_we), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_we", 64'(mem_we), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
          check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
        end
      end
      if (done && error) check("done_and_error", {62'd0, done, error}, 64'd2);
      prev_we = mem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    reset    = 1'b1;
    rx_valid = 1'b1;   // bytes offered under reset must be discarded
    rx_data  = 8'hAA;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    check("rx_ready", 64'(rx_ready), 64'd1);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] n, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], max_gap);
  endtask

  // Header + n payload words from words[] + checksum (optionally corrupted).
  task automatic send_stream(input int n, input logic [7:0] chk_flip, input int max_gap);
    logic [7:0]  chk;
    logic [31:0] w;
    chk = 8'h00;
    send_header(32'(n), max_gap);
    for (int wi = 0; wi < n; wi++) begin
      w = words[wi];
      for (int b = 0; b < 4; b++) begin
        chk = chk ^ w[8*b +: 8];
        if (b == 3) exp_q.push_back({32'(wi * 4), w});
        send_byte(w[8*b +: 8], max_gap);
      end
    end
    check("pre_chk_done", 64'(done), 64'd0);
    check("pre_chk_cpurst", 64'(cpu_reset), 64'd1);
    send_byte(chk ^ chk_flip, max_gap);
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_cpurst"}, 64'(cpu_reset), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_DONE));
  endtask

  task automatic expect_error(input string tag);
    check({tag, "_error"}, 64'(error), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cpurst"}, 64'(cpu_reset), 64'd1);
    check({tag, "_rdy"}, 64'(rx_ready), 64'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr_before;
    reset_dut();

    // Reset values
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_LEN));

    // Single word 0x13, checksum 0x13
    words[0] = 32'h0000_0013;
    send_stream(1, 8'h00, 0);
    expect_done("one");
    check("one_rdy", 64'(rx_ready), 64'd0);
    drain("one");
    check("one_wrcnt", 64'(wr_cnt), 64'd1);

    // Three words back to back, good checksum
    words[0] = 32'h0403_0201;
    words[1] = 32'hA5B6_C7D8;
    words[2] = 32'h00FF_1234;
    reset_dut();
    wr_before = wr_cnt;
    send_stream(3, 8'h00, 0);
    expect_done("three");
    drain("three");
    check("three_wrcnt", 64'(wr_cnt - wr_before), 64'd3);

    // Same stream with corrupted checksum; later bytes must be ignored
    reset_dut();
    wr_before = wr_cnt;
    send_stream(3, 8'h01, 0);
    expect_error("badchk");
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'($urandom_range(255, 0));
      @(posedge clock);
    end
    #1;
    rx_valid = 1'b0;
    expect_error("badchk_after");
    drain("badchk");
    check("badchk_wrcnt", 64'(wr_cnt - wr_before), 64'd3);

    // Length overflow: N = DEPTH_WORDS + 1
    reset_dut();
    wr_before = wr_cnt;
    send_header(32'(DEPTH_WORDS + 1), 0);
    expect_error("ovf");
    check("ovf_state", 64'(dbg_state), 64'(ST_ERROR));
    drain("ovf");
    check("ovf_wrcnt", 64'(wr_cnt - wr_before), 64'd0);

    // Empty program: N = 0, checksum 0x00
    reset_dut();
    wr_before = wr_cnt;
    send_stream(0, 8'h00, 0);
    expect_done("empty");
    drain("empty");
    check("empty_wrcnt", 64'(wr_cnt - wr_before), 64'd0);

    // Three-word stream again with random gaps
    reset_dut();
    wr_before = wr_cnt;
    send_stream(3, 8'h00, 3);
    expect_done("gaps");
    drain("gaps");
    check("gaps_wrcnt", 64'(wr_cnt - wr_before), 64'd3);

    // Reset after 6 payload bytes, then a fresh one-word load
    reset_dut();
    words[0] = 32'h1122_3344;
    words[1] = 32'h5566_7788;
    send_header(32'd2, 0);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) exp_q.push_back({32'd0, words[0]});
      send_byte(words[0][8*b +: 8], 0);
    end
    send_byte(words[1][7:0], 0);
    send_byte(words[1][15:8], 0);
    reset_dut();
    check("midrst_cpurst", 64'(cpu_reset), 64'd1);
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_wdata", 64'(mem_wdata), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(ST_LEN));
    check("midrst_pending", 64'(exp_q.size()), 64'd0);
    wr_before = wr_cnt;
    words[0] = 32'hDEAD_BEEF;
    send_stream(1, 8'h00, 0);
    expect_done("midrst");
    drain("midrst");
    check("midrst_wrcnt", 64'(wr_cnt - wr_before), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. It accepts a byte stream through a valid/ready handshake and checks a length header and an XOR checksum. It packs payload bytes little-endian into XLEN-bit words and writes them to consecutive word addresses from byte address 0. It holds the core in reset until a load completes cleanly, so fetch starts at PC 0 on a fully written program.

## Interface
- XLEN, 32, instruction/data word width; fixed at 32 for RV32I, so 4 bytes per word.
- DEPTH_WORDS, 256, instruction memory capacity in words; maximum accepted length.
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  XLEN  byte address of write; always word-aligned (bits [1:0] = 0).
- mem_wdata  output  XLEN  word to write.
- cpu_reset  output  1  reset to the core/fetch stage; high until successful load.
- done  output  1  load completed, checksum matched; sticky until reset.
- error  output  1  load aborted (length overflow or checksum mismatch); sticky until reset.

## Operation
- A byte is accepted on a clock edge where rx_valid && rx_ready. No other byte has any effect.
- rx_ready = 1 in LEN, DATA and CHECK; 0 in DONE and ERROR. It is a combinational decode of state.
- States: LEN, DATA, CHECK, DONE, ERROR. Reset enters LEN.
- LEN: accept 4 bytes forming a little-endian 32-bit word count N. Byte 0 lands in bits [7:0].
  - After the 4th byte: N > DEPTH_WORDS goes to ERROR; N == 0 goes to CHECK; otherwise goes to DATA.
- DATA: accept 4·N bytes. Byte k (0..3) of each word lands in bits [8k+7:8k].
  - Every payload byte is XORed into an 8-bit checksum register, cleared on reset.
  - On the 4th byte of word i: mem_we=1 on the following cycle, with mem_addr = 4·i and mem_wdata = the assembled word.
  - After word N-1, go to CHECK.
- CHECK: accept 1 byte.
  - If it equals the checksum register (0x00 when N=0), go to DONE. Otherwise go to ERROR.
- DONE: done=1, cpu_reset=0. Remain until reset.
- ERROR: error=1, cpu_reset=1. Remain until reset. Words already written stay in memory; they are not rolled back.
- done and error are never both 1.
- Word index counter width: clog2(DEPTH_WORDS)+1 bits. No wrap-around is possible, because N ≤ DEPTH_WORDS.

## Timing
- Reset values: rx_ready=1 (state LEN), mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0.
- Bytes offered while reset is high are discarded.
- Throughput: one byte per cycle sustained. The loader never deasserts rx_ready inside LEN/DATA/CHECK.
- Write latency: mem_we rises exactly 1 cycle after the edge accepting the word's last byte. It is high for exactly 1 cycle.
  - mem_addr and mem_wdata are registered and stable while mem_we=1. They hold their last values otherwise.
- Completion latency: done/error rise and cpu_reset changes 1 cycle after the edge accepting the checksum byte.
- ERROR on overflow: error rises 1 cycle after the edge accepting the 4th length byte. rx_ready drops in that same cycle.
- Gaps: rx_valid may drop for any number of cycles mid-word or mid-header. Partial assembly and counters hold.
- Reset mid-load: next cycle returns to LEN with counters, checksum and partial word cleared, and cpu_reset=1. A pending mem_we is cancelled.
- The last data word and the checksum byte may arrive on consecutive cycles. mem_we for the last word and CHECK acceptance overlap correctly.

## Structure
- Shared package/header holds the state encodings (LEN, DATA, CHECK, DONE, ERROR) as localparams, plus BYTES_PER_WORD = XLEN/8. The instruction memory and testbench use the same constants.
- Sub-module imem_word_packer contains the byte-lane shift/assembly, the byte-within-word counter and the word-complete pulse. It is reused by the LEN header and DATA paths.
- The top level contains the FSM, word index, checksum, output registers and the cpu_reset/done/error logic.

## Test plan
- Header 01 00 00 00, payload 13 00 00 00, checksum 0x13: one write, mem_addr=0, mem_wdata=0x00000013. Then done=1 and cpu_reset=0, 1 cycle after the checksum byte.
- N=3 of back-to-back bytes, correct checksum: mem_we pulses at addresses 0, 4, 8 with the correct little-endian words; rx_ready stays 1 throughout; done=1.
- Same stream with the checksum XORed with 0x01: all 3 writes occur, then error=1, cpu_reset stays 1, rx_ready=0, and further bytes are ignored.
- Header N=257 with DEPTH_WORDS=256: error=1 after the 4th header byte and no mem_we. Header N=0 with checksum 00: done=1 with no writes.
- Random rx_valid gaps (including mid-word) on the N=3 stream: write addresses and data are identical to the gap-free run.
- Reset asserted after 6 payload bytes, then a full N=1 stream: first write is addr 0 with new data; the stale partial word is never written; done=1.
